sm_imem_boot: RTL and testbench

//  Instruction memory with serial byte loader, directly upstream of the CPU.

---
 rtl/sm_imem_boot_pkg.sv | 23 ++
 rtl/sm_imem_ram.sv | 24 ++
 rtl/sm_imem_boot.sv | 159 +++++++++++++++
 tb/tb_sm_imem_boot.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/sm_imem_boot_pkg.sv
// Shared definitions for the boot-loading instruction memory: loader FSM
// encodings and the word-count overflow helper.
package sm_imem_boot_pkg;

  typedef enum logic [2:0] {
    BOOT_RUN    = 3'd0,
    BOOT_LEN_HI = 3'd1,
    BOOT_LEN_LO = 3'd2,
    BOOT_DATA   = 3'd3,
    BOOT_CSUM   = 3'd4,
    BOOT_ERR    = 3'd5
  } bootState_t;

  localparam int LEN_WIDTH = 16;

  // An image is too large when its word count exceeds the memory depth.
  function automatic logic lenOverflow(input logic [LEN_WIDTH-1:0] n, input int addrWidth);
    logic [LEN_WIDTH:0] depth;
    depth = (LEN_WIDTH+1)'(1) << addrWidth;
    return {1'b0, n} > depth;
  endfunction

endpackage

// File: rtl/sm_imem_ram.sv
// Instruction word storage: one synchronous write port, one asynchronous read
// port; contents are undefined until written by the loader.
module sm_imem_ram #(
  parameter int ADDR_WIDTH = 6,
  parameter     INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wa,
  input  logic [31:0]           wd,
  input  logic [ADDR_WIDTH-1:0] ra,
  output logic [31:0]           rd
);

  logic [31:0] r_mem [0:(2**ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (we) r_mem[wa] <= wd;
  end

  // Reads see the pre-write word during a write cycle.
  assign rd = r_mem[ra];

endmodule

// File: rtl/sm_imem_boot.sv
// Instruction memory with a serial byte loader that holds the CPU in reset
// while a new image streams in. Optional macro: SM_IMEM_BOOT_CHECKSUM_EN.
module sm_imem_boot
  import sm_imem_boot_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter     INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imAddr,
  output logic [31:0] imData,
  input  logic        ld_start,
  input  logic        ld_valid,
  input  logic [7:0]  ld_byte,
  output logic        ld_ready,
  output logic        cpu_rst_n,
  output logic        ld_err
);

`ifdef SM_IMEM_BOOT_CHECKSUM_EN
  localparam bootState_t AFTER_DATA = BOOT_CSUM;
`else
  localparam bootState_t AFTER_DATA = BOOT_RUN;
`endif

  bootState_t             r_state;
  bootState_t             w_next;
  logic [1:0]             r_bcnt;
  logic [LEN_WIDTH-1:0]   r_wcnt;
  logic [LEN_WIDTH-1:0]   r_len;
  logic [7:0]             r_lenHi;
  logic [23:0]            r_asm;
  logic                   r_err;
  logic                   r_cpuRstN;
  logic                   w_ready;
  logic                   w_xfer;
  logic                   w_we;
  logic [LEN_WIDTH-1:0]   w_lenIn;
  logic                   w_lenOvf;
  logic                   w_lastWord;
  logic [ADDR_WIDTH-1:0]  w_rdIdx;
  logic [ADDR_WIDTH-1:0]  w_wrIdx;
`ifdef SM_IMEM_BOOT_CHECKSUM_EN
  logic [7:0]             r_csum;
`endif

  assign w_xfer     = ld_valid & w_ready;
  assign w_lenIn    = {r_lenHi, ld_byte};
  assign w_lenOvf   = lenOverflow(w_lenIn, ADDR_WIDTH);
  assign w_lastWord = (r_wcnt + 16'd1) == r_len;
  assign w_rdIdx    = ADDR_WIDTH'(imAddr);
  assign w_wrIdx    = ADDR_WIDTH'(r_wcnt);
  // ld_start takes priority, so a byte offered in the same cycle is dropped.
  assign w_we       = (r_state == BOOT_DATA) && w_xfer && !ld_start && (r_bcnt == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= BOOT_RUN;
      r_cpuRstN <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_cpuRstN <= (w_next == BOOT_RUN);
    end
  end

  always_comb begin
    w_next = r_state;
    if (ld_start) begin
      w_next = BOOT_LEN_HI;
    end else begin
      case (r_state)
        BOOT_LEN_HI: if (w_xfer) w_next = BOOT_LEN_LO;
        BOOT_LEN_LO: begin
          if (w_xfer) begin
            if (w_lenOvf)              w_next = BOOT_ERR;
            else if (w_lenIn == 16'd0) w_next = AFTER_DATA;
            else                       w_next = BOOT_DATA;
          end
        end
        BOOT_DATA: if (w_xfer && (r_bcnt == 2'd3) && w_lastWord) w_next = AFTER_DATA;
`ifdef SM_IMEM_BOOT_CHECKSUM_EN
        BOOT_CSUM: if (w_xfer) w_next = (ld_byte == r_csum) ? BOOT_RUN : BOOT_ERR;
`endif
        default: w_next = r_state;
      endcase
    end
  end

  always_comb begin
    w_ready = 1'b0;
    case (r_state)
      BOOT_LEN_HI, BOOT_LEN_LO, BOOT_DATA: w_ready = 1'b1;
`ifdef SM_IMEM_BOOT_CHECKSUM_EN
      BOOT_CSUM: w_ready = 1'b1;
`endif
      default: w_ready = 1'b0;
    endcase
  end

  // Bytes arrive little-endian, so each new byte shifts in from the top.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bcnt  <= 2'd0;
      r_wcnt  <= '0;
      r_len   <= '0;
      r_lenHi <= 8'd0;
      r_asm   <= 24'd0;
      r_err   <= 1'b0;
`ifdef SM_IMEM_BOOT_CHECKSUM_EN
      r_csum  <= 8'd0;
`endif
    end else if (ld_start) begin
      r_bcnt  <= 2'd0;
      r_wcnt  <= '0;
      r_err   <= 1'b0;
`ifdef SM_IMEM_BOOT_CHECKSUM_EN
      r_csum  <= 8'd0;
`endif
    end else if (w_xfer) begin
      case (r_state)
        BOOT_LEN_HI: r_lenHi <= ld_byte;
        BOOT_LEN_LO: begin
          r_len <= w_lenIn;
          if (w_lenOvf) r_err <= 1'b1;
        end
        BOOT_DATA: begin
          r_bcnt <= r_bcnt + 2'd1;
          r_asm  <= {ld_byte, r_asm[23:8]};
          if (r_bcnt == 2'd3) r_wcnt <= r_wcnt + 16'd1;
`ifdef SM_IMEM_BOOT_CHECKSUM_EN
          r_csum <= r_csum ^ ld_byte;
`endif
        end
`ifdef SM_IMEM_BOOT_CHECKSUM_EN
        BOOT_CSUM: if (ld_byte != r_csum) r_err <= 1'b1;
`endif
        default: ;
      endcase
    end
  end

  sm_imem_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_FILE  (INIT_FILE)
  ) u_ram (
    .clk (clk),
    .we  (w_we),
    .wa  (w_wrIdx),
    .wd  ({ld_byte, r_asm}),
    .ra  (w_rdIdx),
    .rd  (imData)
  );

  assign ld_ready  = w_ready;
  assign cpu_rst_n = r_cpuRstN;
  assign ld_err    = r_err;

endmodule

// File: tb/tb_sm_imem_boot.sv
// Directed bench for sm_imem_boot: a table-driven N=2 load followed by
// hand-written sequences for empty, overflow, abort, checksum and reset cases.
module tb_sm_imem_boot;

  typedef struct {
    logic       start;
    logic       valid;
    logic [7:0] b;
    logic       expReady;
    logic       expCpuRstN;
    logic       expErr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imAddr;
  logic [31:0] imData;
  logic        ld_start;
  logic        ld_valid;
  logic [7:0]  ld_byte;
  logic        ld_ready;
  logic        cpu_rst_n;
  logic        ld_err;

  int   testsRun    = 0;
  int   testsFailed = 0;
  vec_t vecs[$];
  logic [31:0] mem0Exp;

  sm_imem_boot #(.ADDR_WIDTH(6), .INIT_FILE("")) dut (
    .clk       (clk),
    .rst       (rst),
    .imAddr    (imAddr),
    .imData    (imData),
    .ld_start  (ld_start),
    .ld_valid  (ld_valid),
    .ld_byte   (ld_byte),
    .ld_ready  (ld_ready),
    .cpu_rst_n (cpu_rst_n),
    .ld_err    (ld_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic start, input logic valid, input logic [7:0] b);
    ld_start = start;
    ld_valid = valid;
    ld_byte  = b;
  endtask

  task automatic clockAndClear();
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, 8'h00);
  endtask

  task automatic runVec(input vec_t v, input int idx);
    applyStimulus(v.start, v.valid, v.b);
    #1;
    checkOutput($sformatf("vec%0d ld_ready", idx), {31'd0, ld_ready}, {31'd0, v.expReady});
    clockAndClear();
    checkOutput($sformatf("vec%0d cpu_rst_n", idx), {31'd0, cpu_rst_n}, {31'd0, v.expCpuRstN});
    checkOutput($sformatf("vec%0d ld_err", idx), {31'd0, ld_err}, {31'd0, v.expErr});
  endtask

  task automatic xferByte(input string name, input logic [7:0] b);
    applyStimulus(1'b0, 1'b1, b);
    #1;
    checkOutput({name, " ready"}, {31'd0, ld_ready}, 32'd1);
    clockAndClear();
  endtask

  task automatic pulseStart(input logic valid, input logic [7:0] b);
    applyStimulus(1'b1, valid, b);
    clockAndClear();
  endtask

  task automatic checkRead(input string name, input logic [31:0] addr, input logic [31:0] expected);
    imAddr = addr;
    #1;
    checkOutput(name, imData, expected);
  endtask

  task automatic checkFlags(input string name, input logic rdy, input logic cpu, input logic err);
    checkOutput({name, " ld_ready"}, {31'd0, ld_ready}, {31'd0, rdy});
    checkOutput({name, " cpu_rst_n"}, {31'd0, cpu_rst_n}, {31'd0, cpu});
    checkOutput({name, " ld_err"}, {31'd0, ld_err}, {31'd0, err});
  endtask

  function automatic void addVec(input logic s, input logic v, input logic [7:0] b,
                                 input logic r, input logic c, input logic e);
    vec_t t;
    t.start = s; t.valid = v; t.b = b; t.expReady = r; t.expCpuRstN = c; t.expErr = e;
    vecs.push_back(t);
  endfunction

  initial begin
    // N=2 image 24080013, 2409FFFF with one idle bubble mid-word.
    addVec(1, 0, 8'h00, 0, 0, 0);
    addVec(0, 1, 8'h00, 1, 0, 0);
    addVec(0, 1, 8'h02, 1, 0, 0);
    addVec(0, 1, 8'h13, 1, 0, 0);
    addVec(0, 1, 8'h00, 1, 0, 0);
    addVec(0, 0, 8'h77, 1, 0, 0);
    addVec(0, 1, 8'h08, 1, 0, 0);
    addVec(0, 1, 8'h24, 1, 0, 0);
    addVec(0, 1, 8'hFF, 1, 0, 0);
    addVec(0, 1, 8'hFF, 1, 0, 0);
    addVec(0, 1, 8'h09, 1, 0, 0);
`ifdef SM_IMEM_BOOT_CHECKSUM_EN
    addVec(0, 1, 8'h24, 1, 0, 0);
    addVec(0, 1, 8'h12, 1, 1, 0);
`else
    addVec(0, 1, 8'h24, 1, 1, 0);
`endif
    addVec(0, 0, 8'h00, 0, 1, 0);

    rst    = 1'b1;
    imAddr = 32'd0;
    applyStimulus(1'b0, 1'b0, 8'h00);
    #12;
    checkFlags("reset", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("cpu_rst_n after reset", {31'd0, cpu_rst_n}, 32'd1);

    foreach (vecs[i]) runVec(vecs[i], i);
    checkRead("load2 mem0", 32'd0, 32'h24080013);
    checkRead("load2 mem1", 32'd1, 32'h2409FFFF);
    checkRead("load2 wrap", 32'h41, 32'h2409FFFF);

    // Empty image returns to RUN straight after the length.
    pulseStart(1'b0, 8'h00);
    xferByte("n0 hi", 8'h00);
    xferByte("n0 lo", 8'h00);
`ifdef SM_IMEM_BOOT_CHECKSUM_EN
    checkFlags("n0 pre-csum", 1'b1, 1'b0, 1'b0);
    xferByte("n0 csum", 8'h00);
`endif
    checkFlags("n0 done", 1'b0, 1'b1, 1'b0);
    checkRead("n0 mem0", 32'd0, 32'h24080013);

    // 65 words cannot fit in 64: error, no writes, ignore further bytes.
    pulseStart(1'b0, 8'h00);
    xferByte("ovf hi", 8'h00);
    xferByte("ovf lo", 8'h41);
    checkFlags("ovf", 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 8'hA0 + 8'(i));
      clockAndClear();
    end
    checkFlags("ovf held", 1'b0, 1'b0, 1'b1);
    checkRead("ovf mem0", 32'd0, 32'h24080013);

    // Exactly 64 words is legal; abort it after 5 data bytes.
    pulseStart(1'b0, 8'h00);
    checkFlags("restart", 1'b1, 1'b0, 1'b0);
    xferByte("n64 hi", 8'h00);
    xferByte("n64 lo", 8'h40);
    checkFlags("n64", 1'b1, 1'b0, 1'b0);
    xferByte("n64 b0", 8'hAA);
    xferByte("n64 b1", 8'hBB);
    xferByte("n64 b2", 8'hCC);
    xferByte("n64 b3", 8'hDD);
    xferByte("n64 b4", 8'hEE);
    checkRead("n64 mem0", 32'd0, 32'hDDCCBBAA);
    pulseStart(1'b1, 8'h99);
    checkFlags("abort", 1'b1, 1'b0, 1'b0);
    xferByte("n1 hi", 8'h00);
    xferByte("n1 lo", 8'h01);
    xferByte("n1 b0", 8'h11);
    xferByte("n1 b1", 8'h22);
    xferByte("n1 b2", 8'h33);
    xferByte("n1 b3", 8'h44);
`ifdef SM_IMEM_BOOT_CHECKSUM_EN
    xferByte("n1 csum", 8'h44);
`endif
    checkFlags("n1 done", 1'b0, 1'b1, 1'b0);
    checkRead("abort mem0", 32'd0, 32'h44332211);
    checkRead("abort mem1", 32'd1, 32'h2409FFFF);
    mem0Exp = 32'h44332211;

`ifdef SM_IMEM_BOOT_CHECKSUM_EN
    for (int k = 0; k < 2; k++) begin
      pulseStart(1'b0, 8'h00);
      xferByte("cs hi", 8'h00);
      xferByte("cs lo", 8'h01);
      xferByte("cs b0", 8'h01);
      xferByte("cs b1", 8'h02);
      xferByte("cs b2", 8'h03);
      xferByte("cs b3", 8'h04);
      xferByte("cs csum", (k == 0) ? 8'h04 : 8'h05);
      if (k == 0) checkFlags("cs good", 1'b0, 1'b1, 1'b0);
      else        checkFlags("cs bad", 1'b0, 1'b0, 1'b1);
    end
    checkRead("cs mem0", 32'd0, 32'h04030201);
    mem0Exp = 32'h04030201;
`endif

    // Asynchronous reset in the middle of a word.
    pulseStart(1'b0, 8'h00);
    xferByte("rst hi", 8'h00);
    xferByte("rst lo", 8'h01);
    xferByte("rst b0", 8'h55);
    xferByte("rst b1", 8'h66);
    #2;
    rst = 1'b1;
    #1;
    checkFlags("async rst", 1'b0, 1'b0, 1'b0);
    checkRead("rst wrap mem0", 32'h40, mem0Exp);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkFlags("post rst", 1'b0, 1'b1, 1'b0);
    checkRead("post rst mem0", 32'd0, mem0Exp);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
